// File: rtl/spi_engine.sv
// Byte-wide SPI master (mode 0/2, CPHA=0) driven by extended ctrl codes.
// One data write shifts a full byte out on MOSI while capturing MISO.
module spi_engine #(
   parameter int         DIV_W    = 4,
   parameter logic [3:0] DEV_CFG  = 4'hb,
   parameter logic [3:0] DEV_DATA = 4'hc
) (
   input  logic       CLK,
   input  logic       nRST,
   input  logic       cmd_valid,
   input  logic [3:0] cmd_dev,
   input  logic [7:0] cmd_arg,
   output logic [7:0] status,
   output logic [7:0] rx_data,
   output logic       busy,
   output logic       SCK,
   output logic       MOSI,
   output logic [1:0] nSS,
   input  logic [2:0] MISO
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LEAD,
      S_ACT,
      S_IDL
   } state_t;

   state_t           state_q, state_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       shift_q, shift_d;
   logic [7:0]       rx_q, rx_d;
   logic [1:0]       nss_q, nss_d;
   logic             cpol_q, cpol_d;
   logic             sck_q, sck_d;
   logic             mosi_q, mosi_d;
   logic             done_q, done_d;
   logic             ovr_q, ovr_d;
   logic             miso;

   // With no select asserted, MISO[2] is the input that gets sampled.
   assign miso = (MISO[0] & ~nss_q[0]) | (MISO[1] & ~nss_q[1]) | (MISO[2] & nss_q[0] & nss_q[1]);

   always_comb begin
      // NOTE: every _d defaults to its _q first, so no path through this block can infer a latch.
      state_d = state_q;
      div_d   = div_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      rx_d    = rx_q;
      nss_d   = nss_q;
      cpol_d  = cpol_q;
      sck_d   = sck_q;
      mosi_d  = mosi_q;
      done_d  = done_q;
      ovr_d   = ovr_q;

      if (state_q == S_IDLE) begin
         if (cmd_valid && cmd_dev == DEV_CFG) begin
            div_d  = DIV_W'(cmd_arg[7:4]);
            cpol_d = cmd_arg[3];
            nss_d  = cmd_arg[1:0];
            ovr_d  = 1'b0;
         end else if (cmd_valid && cmd_dev == DEV_DATA) begin
            shift_d = cmd_arg;
            mosi_d  = cmd_arg[7];
            done_d  = 1'b0;
            cnt_d   = div_q;
            bit_d   = 3'd0;
            state_d = S_LEAD;
         end
         sck_d = cpol_d;
      end else begin
         if (cmd_valid && cmd_dev == DEV_DATA) begin
            ovr_d = 1'b1;
         end
         if (cnt_q != '0) begin
            cnt_d = cnt_q - DIV_W'(1);
         end else begin
            cnt_d = div_q;
            if (state_q == S_LEAD) begin
               state_d = S_ACT;
               sck_d   = ~cpol_q;
            end else if (state_q == S_ACT) begin
               state_d = S_IDL;
               sck_d   = cpol_q;
               shift_d = {shift_q[6:0], miso};
            end else if (bit_q != 3'd7) begin
               // TX bits sit above the RX bits already shifted in.
               bit_d   = bit_q + 3'd1;
               mosi_d  = shift_q[7];
               sck_d   = ~cpol_q;
               state_d = S_ACT;
            end else begin
               rx_d    = shift_q;
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
         end
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q <= S_IDLE;
         div_q   <= '0;
         cnt_q   <= '0;
         bit_q   <= 3'd0;
         shift_q <= 8'h00;
         rx_q    <= 8'h00;
         nss_q   <= 2'b11;
         cpol_q  <= 1'b0;
         sck_q   <= 1'b0;
         mosi_q  <= 1'b0;
         done_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking so every register samples the pre-edge values of the others.
         state_q <= state_d;
         div_q   <= div_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         rx_q    <= rx_d;
         nss_q   <= nss_d;
         cpol_q  <= cpol_d;
         sck_q   <= sck_d;
         mosi_q  <= mosi_d;
         done_q  <= done_d;
         ovr_q   <= ovr_d;
      end
   end

   assign busy    = (state_q != S_IDLE);
   assign status  = {busy, done_q, ovr_q, 3'b000, nss_q};
   assign rx_data = rx_q;
   assign SCK     = sck_q;
   assign MOSI    = mosi_q;
   assign nSS     = nss_q;

endmodule

// File: tb/tb_spi_engine.sv
// Self-checking bench for spi_engine: a transfer-level model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_spi_engine;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       cmd_valid = 1'b0;
   logic [3:0] cmd_dev = 4'h0;
   logic [7:0] cmd_arg = 8'h00;
   logic [2:0] miso = 3'b000;
   logic [7:0] status, rx_data;
   logic       busy, sck, mosi;
   logic [1:0] nss;

   always #5 clk = ~clk;

   spi_engine dut (
      .CLK(clk), .nRST(rst_n), .cmd_valid(cmd_valid), .cmd_dev(cmd_dev), .cmd_arg(cmd_arg),
      .status(status), .rx_data(rx_data), .busy(busy), .SCK(sck), .MOSI(mosi), .nSS(nss),
      .MISO(miso)
   );

   int total = 0;
   int bad = 0;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Transfer-level model: a byte transfer is 17 half periods of DIV+1 cycles.
   bit         m_active = 1'b0;
   int         m_t = 0;
   int         m_len = 0;
   logic [3:0] m_div = 4'h0;
   bit         m_cpol = 1'b0;
   logic [1:0] m_nss = 2'b11;
   bit         m_ovr = 1'b0;
   bit         m_done = 1'b0;
   bit         m_idle_mosi = 1'b0;
   logic [7:0] m_tx = 8'h00, m_rx = 8'h00, m_rx_next = 8'h00;
   logic [7:0] s0 = 8'h00, s1 = 8'h00, s2 = 8'h00;

   initial begin : model
      bit was_active;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_active = 1'b0; m_t = 0; m_len = 0; m_div = 4'h0; m_cpol = 1'b0;
            m_nss = 2'b11; m_ovr = 1'b0; m_done = 1'b0; m_idle_mosi = 1'b0;
            m_tx = 8'h00; m_rx = 8'h00; m_rx_next = 8'h00;
         end else begin
            was_active = m_active;
            if (m_active) begin
               if (m_t == m_len - 1) begin
                  m_active = 1'b0; m_done = 1'b1; m_rx = m_rx_next; m_idle_mosi = m_tx[0];
               end else begin
                  m_t++;
               end
            end
            if (cmd_valid) begin
               if (was_active) begin
                  if (cmd_dev == 4'hc) m_ovr = 1'b1;
               end else if (cmd_dev == 4'hb) begin
                  m_div = cmd_arg[7:4]; m_cpol = cmd_arg[3]; m_nss = cmd_arg[1:0]; m_ovr = 1'b0;
               end else if (cmd_dev == 4'hc) begin
                  m_active = 1'b1; m_t = 0; m_len = 17 * (int'(m_div) + 1);
                  m_tx = cmd_arg; m_done = 1'b0;
                  m_rx_next = (m_nss[0] ? 8'h00 : s0) | (m_nss[1] ? 8'h00 : s1) |
                              ((&m_nss) ? s2 : 8'h00);
               end
            end
         end
      end
   end

   // Compare process plus slave-side MISO driver, both on the falling edge.
   initial begin : compare
      int p, b;
      logic e_sck, e_mosi;
      forever begin
         @(negedge clk);
         p = m_t / (int'(m_div) + 1);
         b = (p == 0) ? 0 : (p - 1) / 2;
         e_sck  = m_active ? ((p % 2 == 1) ? ~m_cpol : m_cpol) : m_cpol;
         e_mosi = m_active ? m_tx[7 - b] : m_idle_mosi;
         check("busy", {7'b0, busy}, {7'b0, m_active});
         check("sck", {7'b0, sck}, {7'b0, e_sck});
         check("mosi", {7'b0, mosi}, {7'b0, e_mosi});
         check("nss", {6'b0, nss}, {6'b0, m_nss});
         check("status", status, {m_active, m_done, m_ovr, 3'b000, m_nss});
         check("rx_data", rx_data, m_rx);
         if (!m_active) b = 0;
         miso = {s2[7 - b], s1[7 - b], s0[7 - b]};
      end
   end

   // Waveform measurements used by the literal checks.
   int         busy_cnt = 0, r_prev = 0, r_last = 0;
   logic [7:0] cap = 8'h00;
   bit         got_edge = 1'b0, first_dir = 1'b0;

   initial begin : monitor
      int cyc;
      bit prev;
      cyc = 0;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         if (busy) busy_cnt++;
         if (sck && !prev) begin
            cap = {cap[6:0], mosi};
            r_prev = r_last;
            r_last = cyc;
         end
         if (sck != prev && !got_edge) begin
            got_edge = 1'b1;
            first_dir = sck;
         end
         prev = sck;
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic send(input logic [3:0] d, input logic [7:0] a);
      cmd_dev = d;
      cmd_arg = a;
      cmd_valid = 1'b1;
      @(negedge clk);
      #1;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_idle(input int limit);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         #1;
         n++;
      end while (busy && n < limit);
      check("wait_idle", {7'b0, busy}, 8'h00);
   endtask

   task automatic clear_mon();
      busy_cnt = 0;
      cap = 8'h00;
      got_edge = 1'b0;
      r_prev = 0;
      r_last = 0;
   endtask

   initial begin : stimulus
      #1 rst_n = 1'b0;
      idle(3);
      rst_n = 1'b1;
      idle(2);
      check("rst_sck", {7'b0, sck}, 8'h00);
      check("rst_mosi", {7'b0, mosi}, 8'h00);
      check("rst_nss", {6'b0, nss}, 8'h03);
      check("rst_busy", {7'b0, busy}, 8'h00);
      check("rst_status", status, 8'h03);
      send(4'h5, 8'hff);
      idle(2);
      check("other_dev_ignored", status, 8'h03);

      // Basic byte, DIV=0, MISO[0] returns 3C.
      s0 = 8'h3C; s1 = 8'h00; s2 = 8'hFF;
      send(4'hb, 8'h02);
      idle(1);
      clear_mon();
      send(4'hc, 8'hA5);
      wait_idle(200);
      check("t2_busy_len", 8'(busy_cnt), 8'd17);
      check("t2_mosi_bits", cap, 8'hA5);
      check("t2_rx", rx_data, 8'h3C);
      check("t2_status", status, 8'h42);

      // DIV=3: SCK period 8, busy 68.
      s0 = 8'h5A;
      send(4'hb, 8'h32);
      idle(1);
      clear_mon();
      send(4'hc, 8'hFF);
      wait_idle(300);
      check("t3_busy_len", 8'(busy_cnt), 8'd68);
      check("t3_sck_period", 8'(r_last - r_prev), 8'd8);
      check("t3_mosi_bits", cap, 8'hFF);
      check("t3_rx", rx_data, 8'h5A);

      // Writes while busy, including one on the last busy cycle.
      s0 = 8'h81;
      send(4'hb, 8'h02);
      idle(1);
      clear_mon();
      send(4'hc, 8'h11);
      send(4'hc, 8'h22);
      send(4'hb, 8'h01);
      idle(14);
      send(4'hc, 8'h33);
      wait_idle(100);
      check("t4_busy_len", 8'(busy_cnt), 8'd17);
      check("t4_mosi_bits", cap, 8'h11);
      check("t4_status_ovr", status, 8'h62);
      check("t4_nss", {6'b0, nss}, 8'h02);
      check("t4_rx", rx_data, 8'h81);
      send(4'hb, 8'h02);
      idle(1);
      check("t4_ovr_cleared", status, 8'h42);

      // CPOL=1 with MISO[1], then CPOL=0 with no select (MISO[2]).
      s0 = 8'h3C; s1 = 8'hC3; s2 = 8'h96;
      send(4'hb, 8'h09);
      idle(2);
      check("t5_sck_idle_hi", {7'b0, sck}, 8'h01);
      clear_mon();
      send(4'hc, 8'h5A);
      wait_idle(100);
      check("t5_saw_edge", {7'b0, got_edge}, 8'h01);
      check("t5_first_edge_falls", {7'b0, first_dir}, 8'h00);
      check("t5_rx_miso1", rx_data, 8'hC3);
      check("t5_status", status, 8'h41);
      send(4'hb, 8'h03);
      idle(2);
      check("t5_sck_idle_lo", {7'b0, sck}, 8'h00);
      clear_mon();
      send(4'hc, 8'h00);
      wait_idle(100);
      check("t5_rx_miso2", rx_data, 8'h96);
      check("t5_status_nosel", status, 8'h43);

      // Reset in the middle of bit 4, then a clean transfer.
      s0 = 8'hA5;
      send(4'hb, 8'h12);
      idle(1);
      send(4'hc, 8'hA5);
      idle(18);
      check("t6_mid_busy", {7'b0, busy}, 8'h01);
      check("t6_mid_sck_hi", {7'b0, sck}, 8'h01);
      rst_n = 1'b0;
      #1;
      check("t6_rst_sck", {7'b0, sck}, 8'h00);
      check("t6_rst_mosi", {7'b0, mosi}, 8'h00);
      check("t6_rst_nss", {6'b0, nss}, 8'h03);
      check("t6_rst_busy", {7'b0, busy}, 8'h00);
      check("t6_rst_status", status, 8'h03);
      check("t6_rst_rx", rx_data, 8'h00);
      idle(2);
      rst_n = 1'b1;
      idle(1);
      s2 = 8'h3C;
      clear_mon();
      send(4'hc, 8'h3C);
      wait_idle(100);
      check("t6_busy_len", 8'(busy_cnt), 8'd17);
      check("t6_rx", rx_data, 8'h3C);
      check("t6_mosi_bits", cap, 8'h3C);

      idle(2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
